button_event: RTL and testbench
===============================

# button_event

Press-event classifier that consumes the clean, active-high level from the debouncer and turns it into single-cycle user events. Events are press, release, short press, long press and double click. Sits between the debounce stage and the control logic (mode FSMs, counters, menu logic). A button therefore drives discrete commands instead of being polled as a raw level.

## Interface
- CLK_FREQ_HZ, 50_000_000, system clock frequency in Hz
- LONG_PRESS_MS, 1000, hold time that qualifies a long press
- DOUBLE_CLICK_MS, 300, maximum release-to-second-press gap for a double click
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- db_in  input  1  debounced button level, 1 = pressed; already synchronous to clk
- press_pulse  output  1  one-cycle pulse on every 0->1 of db_in
- release_pulse  output  1  one-cycle pulse on every 1->0 of db_in
- short_press  output  1  one-cycle pulse: single press released before long threshold, no second press within window
- long_press  output  1  one-cycle pulse when hold reaches long threshold
- double_click  output  1  one-cycle pulse on second press inside window
- held  output  1  level, 1 from long_press pulse until release

## Operation
- LONG_CYC = (CLK_FREQ_HZ/1000)*LONG_PRESS_MS.
- DC_CYC = (CLK_FREQ_HZ/1000)*DOUBLE_CLICK_MS.
- Both must be >= 2.
- One shared cycle counter, width $clog2(max(LONG_CYC,DC_CYC)+1), unsigned. It is cleared on every state entry, increments each cycle otherwise, and saturates (never wraps).
- Edge detect: db_q <= db_in (reset 0). rise = db_in & ~db_q; fall = ~db_in & db_q.
- press_pulse and release_pulse fire on every rise/fall, in every state.
- FSM states and transitions:
  - IDLE: rise -> PRESS1.
  - PRESS1: fall -> GAP. Otherwise, counter == LONG_CYC-1 -> LONG, fire long_press.
  - LONG: held=1. fall -> IDLE. No short_press or double_click is generated from LONG.
  - GAP: rise -> PRESS2, fire double_click. Otherwise, counter == DC_CYC-1 -> IDLE, fire short_press.
  - PRESS2: fall -> IDLE. No long detection in this state; a held second press generates nothing further.
- Unreachable or illegal state encodings -> IDLE, no pulse.
- Simultaneous events, edge wins:
  - PRESS1: fall in the same cycle as counter == LONG_CYC-1 -> GAP, no long_press.
  - GAP: rise in the same cycle as counter == DC_CYC-1 -> double_click, no short_press.
- At most one of short_press, long_press or double_click is high in any cycle. Each press sequence generates exactly one classified event, or none if reset intervenes.

## Timing
- All outputs are registered.
- Reset value of every output is 0, with state IDLE, counter 0 and db_q 0.
- Reset mid-sequence aborts it silently: no pending pulse is generated after reset release.
- If db_in is 1 at reset release, the first cycle produces a rise (press_pulse) and enters PRESS1.
- Latency, taking cycle T as the first cycle db_in is sampled at its new value:
  - press_pulse / release_pulse: high in cycle T+1, for exactly 1 cycle.
  - long_press: high LONG_CYC cycles after press_pulse. held rises in the same cycle.
  - held falls in the same cycle release_pulse rises.
  - double_click: coincident with the second press_pulse.
  - short_press: DC_CYC cycles after the release_pulse.
- Back-to-back edges on consecutive cycles are handled without loss. The debouncer normally prevents them.

## Test plan
All scenarios use CLK_FREQ_HZ=1000, LONG_PRESS_MS=8, DOUBLE_CLICK_MS=4, giving LONG_CYC=8 and DC_CYC=4.
- Short press: db_in high 3 cycles then low -> press_pulse and release_pulse once each; short_press once, 4 cycles after release_pulse; no long_press, double_click or held.
- Long press: db_in high 20 cycles -> long_press 8 cycles after press_pulse; held=1 until release_pulse cycle; no short_press afterwards.
- Double click: high 2, low 2, high 2, low -> double_click coincident with the second press_pulse; no short_press or long_press.
- Boundary: fall in the exact cycle the counter reaches 7 -> short_press path, no long_press. Second rise in the exact cycle the GAP counter reaches 3 -> double_click, no short_press.
- Late second press: high 2, low 5, high 2, low -> two separate short_press pulses, no double_click.
- Reset mid-operation: assert rst_n=0 during GAP (counter=2), release with db_in=0 -> all outputs 0, no short_press ever. Repeat with db_in=1 at release -> press_pulse on the first cycle after release.

Source files
------------

// File: rtl/button_event.sv
// Classifies a debounced button level into single-cycle events: press, release,
// short press, long press and double click, plus a held level after a long press.
module button_event #(
   parameter int CLK_FREQ_HZ     = 50_000_000,
   parameter int LONG_PRESS_MS   = 1000,
   parameter int DOUBLE_CLICK_MS = 300
) (
   input  logic clk,
   input  logic rst_n,
   input  logic db_in,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_press,
   output logic long_press,
   output logic double_click,
   output logic held
);

   localparam int LONG_CYC = (CLK_FREQ_HZ / 1000) * LONG_PRESS_MS;
   localparam int DC_CYC   = (CLK_FREQ_HZ / 1000) * DOUBLE_CLICK_MS;
   localparam int MAX_CYC  = (LONG_CYC > DC_CYC) ? LONG_CYC : DC_CYC;
   localparam int CNT_W    = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] DC_LAST   = CNT_W'(DC_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      LONG   = 3'd2,
      GAP    = 3'd3,
      PRESS2 = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             db_q;
   logic             rise;
   logic             fall;

   assign rise = db_in & ~db_q;
   assign fall = ~db_in & db_q;

   // Edges take priority over counter thresholds so a release or second press
   // landing on the exact threshold cycle is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         db_q          <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_press   <= 1'b0;
         long_press    <= 1'b0;
         double_click  <= 1'b0;
         held          <= 1'b0;
      end else begin
         db_q          <= db_in;
         press_pulse   <= rise;
         release_pulse <= fall;
         short_press   <= 1'b0;
         long_press    <= 1'b0;
         double_click  <= 1'b0;
         if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (rise) begin
                  state <= PRESS1;
                  cnt   <= '0;
               end
            end
            PRESS1: begin
               if (fall) begin
                  state <= GAP;
                  cnt   <= '0;
               end else if (cnt == LONG_LAST) begin
                  state      <= LONG;
                  cnt        <= '0;
                  long_press <= 1'b1;
                  held       <= 1'b1;
               end
            end
            LONG: begin
               if (fall) begin
                  state <= IDLE;
                  cnt   <= '0;
                  held  <= 1'b0;
               end
            end
            GAP: begin
               if (rise) begin
                  state        <= PRESS2;
                  cnt          <= '0;
                  double_click <= 1'b1;
               end else if (cnt == DC_LAST) begin
                  state       <= IDLE;
                  cnt         <= '0;
                  short_press <= 1'b1;
               end
            end
            PRESS2: begin
               if (fall) begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               held  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: each step drives db_in for one clock and
// queues the expected output vector, which is popped and checked after the edge.
module tb_button_event;

   logic clk;
   logic rst_n;
   logic db_in;
   logic press_pulse;
   logic release_pulse;
   logic short_press;
   logic long_press;
   logic double_click;
   logic held;

   // Vector order: {press, release, short, long, double, held}
   localparam logic [5:0] Z = 6'b000000;
   localparam logic [5:0] P = 6'b100000;
   localparam logic [5:0] R = 6'b010000;
   localparam logic [5:0] S = 6'b001000;
   localparam logic [5:0] L = 6'b000100;
   localparam logic [5:0] D = 6'b000010;
   localparam logic [5:0] H = 6'b000001;

   logic [5:0] expQ[$];
   int         assertCount = 0;
   int         failCount   = 0;
   int         stepIdx     = 0;
   string      scenario    = "reset";

   button_event #(
      .CLK_FREQ_HZ     (1000),
      .LONG_PRESS_MS   (8),
      .DOUBLE_CLICK_MS (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .db_in         (db_in),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .short_press   (short_press),
      .long_press    (long_press),
      .double_click  (double_click),
      .held          (held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] observed();
      return {press_pulse, release_pulse, short_press, long_press, double_click, held};
   endfunction

   task automatic checkOutput();
      logic [5:0] exp;
      logic [5:0] obs;
      exp = expQ.pop_front();
      obs = observed();
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s step %0d: observed %b expected %b", scenario, stepIdx, obs, exp);
      end
   endtask

   task automatic checkIdle(input string tag);
      logic [5:0] obs;
      obs = observed();
      assertCount++;
      assert (obs === Z) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, Z);
      end
   endtask

   task automatic applyStimulus(input logic din, input logic [5:0] exp);
      db_in = din;
      expQ.push_back(exp);
      @(posedge clk);
      #1;
      stepIdx++;
      checkOutput();
   endtask

   task automatic applyRun(input logic din, input int n, input logic [5:0] exp);
      for (int i = 0; i < n; i++) begin
         applyStimulus(din, exp);
      end
   endtask

   task automatic startScenario(input string name);
      scenario = name;
      stepIdx  = 0;
      $display("[TB] scenario %s", name);
   endtask

   initial begin
      rst_n = 1'b0;
      db_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkIdle("reset_state");
      rst_n = 1'b1;
      applyRun(1'b0, 2, Z);

      startScenario("short_press");
      applyStimulus(1'b1, P);
      applyRun(1'b1, 2, Z);
      applyStimulus(1'b0, R);
      applyRun(1'b0, 3, Z);
      applyStimulus(1'b0, S);
      applyRun(1'b0, 3, Z);

      startScenario("long_press");
      applyStimulus(1'b1, P);
      applyRun(1'b1, 7, Z);
      applyStimulus(1'b1, L | H);
      applyRun(1'b1, 11, H);
      applyStimulus(1'b0, R);
      applyRun(1'b0, 6, Z);

      startScenario("double_click");
      applyStimulus(1'b1, P);
      applyStimulus(1'b1, Z);
      applyStimulus(1'b0, R);
      applyStimulus(1'b0, Z);
      applyStimulus(1'b1, P | D);
      applyStimulus(1'b1, Z);
      applyStimulus(1'b0, R);
      applyRun(1'b0, 6, Z);

      startScenario("long_boundary");
      applyStimulus(1'b1, P);
      applyRun(1'b1, 7, Z);
      applyStimulus(1'b0, R);
      applyRun(1'b0, 3, Z);
      applyStimulus(1'b0, S);
      applyRun(1'b0, 2, Z);

      startScenario("gap_boundary");
      applyStimulus(1'b1, P);
      applyStimulus(1'b1, Z);
      applyStimulus(1'b0, R);
      applyRun(1'b0, 3, Z);
      applyStimulus(1'b1, P | D);
      applyStimulus(1'b1, Z);
      applyStimulus(1'b0, R);
      applyRun(1'b0, 6, Z);

      startScenario("late_second_press");
      applyStimulus(1'b1, P);
      applyStimulus(1'b1, Z);
      applyStimulus(1'b0, R);
      applyRun(1'b0, 3, Z);
      applyStimulus(1'b0, S);
      applyStimulus(1'b1, P);
      applyStimulus(1'b1, Z);
      applyStimulus(1'b0, R);
      applyRun(1'b0, 3, Z);
      applyStimulus(1'b0, S);
      applyRun(1'b0, 2, Z);

      startScenario("reset_in_gap_low");
      applyStimulus(1'b1, P);
      applyStimulus(1'b1, Z);
      applyStimulus(1'b0, R);
      applyRun(1'b0, 2, Z);
      rst_n = 1'b0;
      #1;
      checkIdle("reset_in_gap_low_asserted");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyRun(1'b0, 8, Z);

      startScenario("reset_in_gap_high");
      applyStimulus(1'b1, P);
      applyStimulus(1'b1, Z);
      applyStimulus(1'b0, R);
      applyRun(1'b0, 2, Z);
      rst_n = 1'b0;
      db_in = 1'b1;
      #1;
      checkIdle("reset_in_gap_high_asserted");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b1, P);
      applyRun(1'b1, 2, Z);
      applyStimulus(1'b0, R);
      applyRun(1'b0, 3, Z);
      applyStimulus(1'b0, S);
      applyRun(1'b0, 2, Z);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
